uart_bus_arbiter: RTL

- Shares the single register bus of the uart1 core (write-enable, address, write data, read data) between two requesters, e.g. the host CPU port and a configuration/test sequencer.
- Arbitrates round-robin, with an optional per-requester lock for atomic multi-access sequences.
- Issues exactly one bus access per grant, waits out the read latency and returns a one-cycle acknowledge with read data.
- Sits between the requesters and the uart1 bus pins, in the same clock domain.

---
 rtl/uart_bus_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter that shares the uart1 register bus between two requesters.
// One bus access per grant, optional owner lock, one-cycle ack with captured read data.
module uart_bus_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    state_t     state;
    logic [2:0] count;
    logic       winner;
    logic       last_grant;
    logic       lock_valid;
    logic       lock_id;
    logic       lat_we;
    logic       lat_lock;

    logic       elig0;
    logic       elig1;
    logic       pick;

    // While a lock is held only the owner may win; ties go to whoever was not granted last.
    always_comb begin
        elig0 = i_req0 && (!lock_valid || !lock_id);
        elig1 = i_req1 && (!lock_valid ||  lock_id);
        pick  = (elig0 && elig1) ? ~last_grant : elig1;
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            count      <= '0;
            winner     <= 1'b0;
            last_grant <= 1'b1;
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
            lat_we     <= 1'b0;
            lat_lock   <= 1'b0;
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_rdata0   <= '0;
            o_rdata1   <= '0;
            o_we       <= 1'b0;
            o_address  <= '0;
            o_data     <= '0;
        end else begin
            o_we   <= 1'b0;
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        winner    <= pick;
                        lat_we    <= pick ? i_we1   : i_we0;
                        lat_lock  <= pick ? i_lock1 : i_lock0;
                        o_we      <= pick ? i_we1   : i_we0;
                        o_address <= pick ? i_addr1 : i_addr0;
                        o_data    <= pick ? i_wdata1 : i_wdata0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        o_ack0 <= ~winner;
                        o_ack1 <= winner;
                        state  <= DONE;
                    end else if (READ_LAT == 1) begin
                        if (winner) o_rdata1 <= i_data;
                        else        o_rdata0 <= i_data;
                        o_ack0 <= ~winner;
                        o_ack1 <= winner;
                        state  <= DONE;
                    end else begin
                        count <= LAT_M1;
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    // The edge that takes the counter to zero is the read capture edge.
                    if (count == 3'd1) begin
                        if (winner) o_rdata1 <= i_data;
                        else        o_rdata0 <= i_data;
                        o_ack0 <= ~winner;
                        o_ack1 <= winner;
                        count  <= '0;
                        state  <= DONE;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                DONE: begin
                    last_grant <= winner;
                    lock_valid <= lat_lock;
                    lock_id    <= winner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
